// File: rtl/upstream_risk_engine_if.sv
// upstream_risk_engine_if
//   Request/response bundle for the upstream pre-trade risk engine.
//   The request side is a valid/ready handshake. The response side is a
//   one-cycle rsp_valid pulse with no backpressure. The rsp_* fields hold
//   their values until the next response.
//
//   Signals:
//     req_valid    request present (master -> engine)
//     req_ready    engine can take a request this cycle (engine -> master)
//     req_op       00 order, 01 cancel, 10 limit update, 11 query
//     req_client   client id
//     req_amount   order/cancel amount, or new limit
//     rsp_valid    one-cycle response pulse
//     rsp_accept   1 = request accepted/applied
//     rsp_reason   00 ok, 01 limit, 10 bad client, 11 cancel clamped
//     rsp_client   client id of the response
//     rsp_exposure accumulated exposure after the operation
//
//   Modports: master (request source / response sink), slave (engine).
interface upstream_risk_engine_if #(
  parameter int CLIENT_W = 5,
  parameter int AMT_W    = 16
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [CLIENT_W-1:0] req_client;
  logic [AMT_W-1:0]    req_amount;

  logic                rsp_valid;
  logic                rsp_accept;
  logic [1:0]          rsp_reason;
  logic [CLIENT_W-1:0] rsp_client;
  logic [AMT_W-1:0]    rsp_exposure;

  modport master (
    output req_valid, req_op, req_client, req_amount,
    input  req_ready,
    input  rsp_valid, rsp_accept, rsp_reason, rsp_client, rsp_exposure
  );

  modport slave (
    input  req_valid, req_op, req_client, req_amount,
    output req_ready,
    output rsp_valid, rsp_accept, rsp_reason, rsp_client, rsp_exposure
  );
endinterface

// File: rtl/upstream_risk_engine.sv
// upstream_risk_engine
//   Pre-trade risk engine for the upstream path. It keeps a per-client
//   table of accumulated exposure and max-to-trade limit. It services
//   order, cancel, limit-update and query requests one at a time using a
//   READ -> CHECK -> WRITE sequence. Each request ends with a one-cycle
//   response that feeds the order-send stage.
//
//   Ports:
//     clk        single clock, rising edge
//     HRESETn    asynchronous, active-low reset
//     bus        upstream_risk_engine_if.slave (request handshake + response)
//     init_done  table initialisation complete (sticky until reset)
//
//   Optional feature macro: LIMIT_DECREASE_EN
//     defined   : a limit update always writes the new limit, including
//                 lowering it or setting it to 0, and is always accepted.
//     undefined : a limit update may only raise the limit.
//                 Otherwise it is rejected with reason 01.
module upstream_risk_engine #(
  parameter int NUM_CLIENTS = 32,
  parameter int CLIENT_W    = 5,
  parameter int AMT_W       = 16
) (
  input  logic                   clk,
  input  logic                   HRESETn,
  upstream_risk_engine_if.slave  bus,
  output logic                   init_done
);

  localparam int IDX_W = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX     = IDX_W'(NUM_CLIENTS - 1);
  // One extra bit lets the compare work when NUM_CLIENTS == 2**CLIENT_W.
  localparam logic [CLIENT_W:0] CLIENT_LIMIT = (CLIENT_W + 1)'(NUM_CLIENTS);

  localparam logic [1:0] OP_ORDER  = 2'b00;
  localparam logic [1:0] OP_CANCEL = 2'b01;
  localparam logic [1:0] OP_LIMIT  = 2'b10;

  localparam logic [1:0] RSN_OK     = 2'b00;
  localparam logic [1:0] RSN_LIMIT  = 2'b01;
  localparam logic [1:0] RSN_BAD    = 2'b10;
  localparam logic [1:0] RSN_CLAMP  = 2'b11;

  typedef enum logic [2:0] {INIT, IDLE, READ, CHECK, WRITE} state_t;

  state_t              state;
  logic [IDX_W-1:0]    sweep;
  logic [1:0]          op_q;
  logic [CLIENT_W-1:0] client_q;
  logic                client_ok_q;
  logic [AMT_W-1:0]    amount_q;
  logic [AMT_W-1:0]    acc_q;
  logic [AMT_W-1:0]    lim_q;
  logic [AMT_W-1:0]    new_acc_q;
  logic [AMT_W-1:0]    new_lim_q;
  logic                acc_we_q;
  logic                lim_we_q;

  logic [AMT_W-1:0]    acc_mem [NUM_CLIENTS];
  logic [AMT_W-1:0]    lim_mem [NUM_CLIENTS];

  logic [IDX_W-1:0]    idx;
  assign idx = client_q[IDX_W-1:0];

  // Decision logic for the CHECK cycle. It works from the captured request
  // and the table entry read in READ. An order is tested at AMT_W+1 bits
  // against a strict limit, so an accepted sum always fits in AMT_W bits.
  logic [AMT_W:0]   sum;
  logic             chk_accept;
  logic [1:0]       chk_reason;
  logic [AMT_W-1:0] chk_exposure;
  logic [AMT_W-1:0] chk_acc;
  logic [AMT_W-1:0] chk_lim;
  logic             chk_acc_we;
  logic             chk_lim_we;

  always_comb begin
    sum          = {1'b0, acc_q} + {1'b0, amount_q};
    chk_accept   = 1'b0;
    chk_reason   = RSN_OK;
    chk_exposure = acc_q;
    chk_acc      = acc_q;
    chk_lim      = lim_q;
    chk_acc_we   = 1'b0;
    chk_lim_we   = 1'b0;
    if (!client_ok_q) begin
      chk_reason   = RSN_BAD;
      chk_exposure = '0;
    end else begin
      case (op_q)
        OP_ORDER: begin
          if (sum < {1'b0, lim_q}) begin
            chk_accept   = 1'b1;
            chk_acc      = sum[AMT_W-1:0];
            chk_acc_we   = 1'b1;
            chk_exposure = sum[AMT_W-1:0];
          end else begin
            chk_reason = RSN_LIMIT;
          end
        end
        OP_CANCEL: begin
          chk_accept = 1'b1;
          chk_acc_we = 1'b1;
          if (amount_q <= acc_q) begin
            chk_acc = acc_q - amount_q;
          end else begin
            chk_acc    = '0;
            chk_reason = RSN_CLAMP;
          end
          chk_exposure = chk_acc;
        end
        OP_LIMIT: begin
`ifdef LIMIT_DECREASE_EN
          chk_accept = 1'b1;
          chk_lim    = amount_q;
          chk_lim_we = 1'b1;
`else
          if (amount_q > lim_q) begin
            chk_accept = 1'b1;
            chk_lim    = amount_q;
            chk_lim_we = 1'b1;
          end else begin
            chk_reason = RSN_LIMIT;
          end
`endif
        end
        default: begin
          chk_accept = 1'b1;
        end
      endcase
    end
  end

  // Main controller. INIT sweeps the table, one entry per cycle. After that
  // each request walks IDLE -> READ -> CHECK -> WRITE, and only one request
  // is ever outstanding. All outputs are registered. rsp_valid is raised
  // when entering WRITE, so the pulse coincides with the table commit.
  always_ff @(posedge clk or negedge HRESETn) begin
    if (!HRESETn) begin
      state            <= INIT;
      sweep            <= '0;
      init_done        <= 1'b0;
      bus.req_ready    <= 1'b0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_accept   <= 1'b0;
      bus.rsp_reason   <= RSN_OK;
      bus.rsp_client   <= '0;
      bus.rsp_exposure <= '0;
      op_q             <= '0;
      client_q         <= '0;
      client_ok_q      <= 1'b0;
      amount_q         <= '0;
      acc_q            <= '0;
      lim_q            <= '0;
      new_acc_q        <= '0;
      new_lim_q        <= '0;
      acc_we_q         <= 1'b0;
      lim_we_q         <= 1'b0;
    end else begin
      bus.rsp_valid <= 1'b0;
      case (state)
        INIT: begin
          if (sweep == LAST_IDX) begin
            state         <= IDLE;
            init_done     <= 1'b1;
            bus.req_ready <= 1'b1;
          end else begin
            sweep <= sweep + IDX_W'(1);
          end
        end
        IDLE: begin
          if (bus.req_valid) begin
            op_q          <= bus.req_op;
            client_q      <= bus.req_client;
            client_ok_q   <= ({1'b0, bus.req_client} < CLIENT_LIMIT);
            amount_q      <= bus.req_amount;
            bus.req_ready <= 1'b0;
            state         <= READ;
          end
        end
        READ: begin
          if (client_ok_q) begin
            acc_q <= acc_mem[idx];
            lim_q <= lim_mem[idx];
          end
          state <= CHECK;
        end
        CHECK: begin
          new_acc_q        <= chk_acc;
          new_lim_q        <= chk_lim;
          acc_we_q         <= chk_acc_we;
          lim_we_q         <= chk_lim_we;
          bus.rsp_valid    <= 1'b1;
          bus.rsp_accept   <= chk_accept;
          bus.rsp_reason   <= chk_reason;
          bus.rsp_client   <= client_q;
          bus.rsp_exposure <= chk_exposure;
          state            <= WRITE;
        end
        WRITE: begin
          bus.req_ready <= 1'b1;
          state         <= IDLE;
        end
        default: begin
          state <= INIT;
        end
      endcase
    end
  end

  // The table write port is shared by the INIT sweep and the WRITE commit.
  // The two never overlap because they belong to different states.
  logic             mem_acc_we;
  logic             mem_lim_we;
  logic [IDX_W-1:0] mem_addr;
  logic [AMT_W-1:0] mem_acc_d;
  logic [AMT_W-1:0] mem_lim_d;

  always_comb begin
    mem_acc_we = 1'b0;
    mem_lim_we = 1'b0;
    mem_addr   = sweep;
    mem_acc_d  = '0;
    mem_lim_d  = '0;
    if (state == INIT) begin
      mem_acc_we = 1'b1;
      mem_lim_we = 1'b1;
    end else if (state == WRITE) begin
      mem_acc_we = acc_we_q;
      mem_lim_we = lim_we_q;
      mem_addr   = idx;
      mem_acc_d  = new_acc_q;
      mem_lim_d  = new_lim_q;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_acc_we) acc_mem[mem_addr] <= mem_acc_d;
    if (mem_lim_we) lim_mem[mem_addr] <= mem_lim_d;
  end

endmodule

// File: tb/tb_upstream_risk_engine.sv
// tb_upstream_risk_engine
//   Directed bench for upstream_risk_engine. It is built with CLIENT_W=6,
//   so out-of-range client ids (>= 32) can be driven. A client-table model
//   predicts every response. A negedge monitor compares each rsp_valid
//   pulse against that model, including the three-cycle latency.
//   Hand-computed literals pin the model after each transaction.
//   Honours LIMIT_DECREASE_EN in the same way as the design.
module tb_upstream_risk_engine;

  localparam int NUM_CLIENTS = 32;
  localparam int CLIENT_W    = 6;
  localparam int AMT_W       = 16;
`ifdef LIMIT_DECREASE_EN
  localparam int DEC = 1;
`else
  localparam int DEC = 0;
`endif

  logic clk = 1'b0;
  logic HRESETn = 1'b0;
  logic init_done;

  always #5 clk = ~clk;

  upstream_risk_engine_if #(.CLIENT_W(CLIENT_W), .AMT_W(AMT_W)) bus();

  upstream_risk_engine #(
    .NUM_CLIENTS(NUM_CLIENTS),
    .CLIENT_W(CLIENT_W),
    .AMT_W(AMT_W)
  ) dut (
    .clk(clk),
    .HRESETn(HRESETn),
    .bus(bus),
    .init_done(init_done)
  );

  typedef struct {
    int accept;
    int reason;
    int client;
    int exposure;
    int due;
  } exp_t;

  exp_t exp_q[$];
  exp_t cmp_e;
  int   m_acc[NUM_CLIENTS];
  int   m_lim[NUM_CLIENTS];
  int   checks = 0;
  int   errors = 0;
  int   neg_cyc = 0;
  int   rsp_count = 0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Client-table model: plain integer arithmetic on the rules for each op.
  function automatic exp_t modelRequest(input int op, input int client, input int amt);
    exp_t e;
    e.client   = client;
    e.accept   = 0;
    e.reason   = 0;
    e.exposure = 0;
    e.due      = 0;
    if (client >= NUM_CLIENTS) begin
      e.reason = 2;
      return e;
    end
    case (op)
      0: begin
        if (m_acc[client] + amt < m_lim[client]) begin
          m_acc[client] = m_acc[client] + amt;
          e.accept = 1;
        end else begin
          e.reason = 1;
        end
      end
      1: begin
        e.accept = 1;
        if (amt <= m_acc[client]) begin
          m_acc[client] = m_acc[client] - amt;
        end else begin
          m_acc[client] = 0;
          e.reason = 3;
        end
      end
      2: begin
        if (DEC == 1 || amt > m_lim[client]) begin
          m_lim[client] = amt;
          e.accept = 1;
        end else begin
          e.reason = 1;
        end
      end
      default: e.accept = 1;
    endcase
    e.exposure = m_acc[client];
    return e;
  endfunction

  task automatic modelReset();
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      m_acc[i] = 0;
      m_lim[i] = 0;
    end
  endtask

  // Response monitor: every pulse must match the oldest prediction on its due cycle.
  always @(negedge clk) begin
    neg_cyc++;
    if (bus.rsp_valid === 1'b1) begin
      rsp_count++;
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_rsp", 1, 0);
      end else begin
        cmp_e = exp_q.pop_front();
        checkOutput("rsp_latency", neg_cyc, cmp_e.due);
        checkOutput("rsp_accept", int'(bus.rsp_accept), cmp_e.accept);
        checkOutput("rsp_reason", int'(bus.rsp_reason), cmp_e.reason);
        checkOutput("rsp_client", int'(bus.rsp_client), cmp_e.client);
        checkOutput("rsp_exposure", int'(bus.rsp_exposure), cmp_e.exposure);
      end
    end else if (exp_q.size() > 0 && neg_cyc > exp_q[0].due) begin
      checkOutput("rsp_missing", 0, 1);
      exp_q.delete(0);
    end
  end

  // Called at negedge+1; returns at posedge+1 just after the handshake (engine in READ).
  task automatic applyStimulus(input int op, input int client, input int amt, input bit expect_rsp);
    int waited = 0;
    bus.req_op     = 2'(op);
    bus.req_client = CLIENT_W'(client);
    bus.req_amount = AMT_W'(amt);
    bus.req_valid  = 1'b1;
    while (bus.req_ready !== 1'b1 && waited < 60) begin
      @(negedge clk);
      #1;
      waited++;
    end
    if (bus.req_ready !== 1'b1) begin
      checkOutput("ready_timeout", 0, 1);
      bus.req_valid = 1'b0;
      return;
    end
    if (expect_rsp) begin
      exp_t e;
      e = modelRequest(op, client, amt);
      e.due = neg_cyc + 3;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic waitResponse();
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checkOutput("rsp_timeout", 0, 1);
      exp_q.delete();
    end
  endtask

  task automatic txn(input string name, input int op, input int client, input int amt,
                     input int ea, input int er, input int ee);
    applyStimulus(op, client, amt, 1'b1);
    waitResponse();
    checkOutput({name, "_accept"}, int'(bus.rsp_accept), ea);
    checkOutput({name, "_reason"}, int'(bus.rsp_reason), er);
    checkOutput({name, "_exposure"}, int'(bus.rsp_exposure), ee);
  endtask

  task automatic waitInit();
    int n = 0;
    while (bus.req_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("reinit_ready", int'(bus.req_ready), 1);
    checkOutput("reinit_done", int'(init_done), 1);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_client = '0;
    bus.req_amount = '0;
    modelReset();

    // Reset values, with a request held pending across initialisation.
    repeat (3) @(negedge clk);
    #1;
    checkOutput("reset_req_ready", int'(bus.req_ready), 0);
    checkOutput("reset_rsp_valid", int'(bus.rsp_valid), 0);
    checkOutput("reset_rsp_accept", int'(bus.rsp_accept), 0);
    checkOutput("reset_rsp_reason", int'(bus.rsp_reason), 0);
    checkOutput("reset_rsp_client", int'(bus.rsp_client), 0);
    checkOutput("reset_rsp_exposure", int'(bus.rsp_exposure), 0);
    checkOutput("reset_init_done", int'(init_done), 0);
    bus.req_valid = 1'b1;
    HRESETn = 1'b1;
    for (int i = 0; i < 32; i++) begin
      checkOutput("init_ready_low", int'(bus.req_ready), 0);
      checkOutput("init_done_low", int'(init_done), 0);
      @(negedge clk);
      #1;
    end
    checkOutput("init_ready_high", int'(bus.req_ready), 1);
    checkOutput("init_done_high", int'(init_done), 1);
    bus.req_valid = 1'b0;

    // Limit 0 rejects every order, even amount 0.
    txn("c3_order10_lim0", 0, 3, 10, 0, 1, 0);
    txn("c3_order0_lim0", 0, 3, 0, 0, 1, 0);

    // Raise limit, fill up to limit-1, then hit the strict boundary.
    txn("c3_limit100", 2, 3, 100, 1, 0, 0);
    txn("c3_order60", 0, 3, 60, 1, 0, 60);
    txn("c3_order39", 0, 3, 39, 1, 0, 99);
    txn("c3_order1_edge", 0, 3, 1, 0, 1, 99);

    // Cancels: normal, then clamped to zero.
    txn("c3_cancel50", 1, 3, 50, 1, 0, 49);
    txn("c3_cancel80", 1, 3, 80, 1, 3, 0);
    txn("c3_query", 3, 3, 0, 1, 0, 0);

    // Full-width limit and the 17-bit sum boundary.
    txn("c31_limitmax", 2, 31, 65535, 1, 0, 0);
    txn("c31_orderFFFE", 0, 31, 65534, 1, 0, 65534);
    txn("c31_order2_ovf", 0, 31, 2, 0, 1, 65534);
    txn("c31_order0", 0, 31, 0, 1, 0, 65534);

    // Out-of-range clients.
    txn("c32_query", 3, 32, 0, 0, 2, 0);
    txn("c63_order", 0, 63, 5, 0, 2, 0);
    checkOutput("c63_rsp_client", int'(bus.rsp_client), 63);

    // Limit decrease behaviour depends on LIMIT_DECREASE_EN.
    txn("c7_limit100", 2, 7, 100, 1, 0, 0);
    txn("c7_limit50", 2, 7, 50, DEC, 1 - DEC, 0);
    txn("c7_order50", 0, 7, 50, 1 - DEC, DEC, 50 * (1 - DEC));

    // Reset while the engine is in READ: the request is dropped and the table is re-initialised.
    rsp_count = 0;
    applyStimulus(0, 3, 5, 1'b0);
    HRESETn = 1'b0;
    #1;
    checkOutput("midrst_ready", int'(bus.req_ready), 0);
    checkOutput("midrst_done", int'(init_done), 0);
    repeat (4) @(negedge clk);
    #1;
    HRESETn = 1'b1;
    modelReset();
    waitInit();
    checkOutput("midrst_no_rsp", rsp_count, 0);
    txn("post_rst_c3_query", 3, 3, 0, 1, 0, 0);
    txn("post_rst_c31_query", 3, 31, 0, 1, 0, 0);
    txn("post_rst_c31_order", 0, 31, 1, 0, 1, 0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/upstream_risk_engine.md
Name: upstream_risk_engine

Overview:
- Parametrised pre-trade risk engine for the upstream path.
- Holds a per-client table of accumulated exposure and max-to-trade limit, and services order, cancel, limit-update and query requests through a valid/ready handshake.
- Each request runs a read-check-write sequence and returns a one-cycle accept/reject response, which feeds the order-send stage.

Parameters:
- NUM_CLIENTS, 32, number of client entries in the table.
- CLIENT_W, 5, client id width; must satisfy 2**CLIENT_W >= NUM_CLIENTS.
- AMT_W, 16, width of amounts, accumulated exposure and limits.

Ports:
- clk  in  1  single clock, rising edge.
- HRESETn  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  engine can take a request this cycle.
- req_op  in  2  00 order, 01 cancel, 10 limit update, 11 query.
- req_client  in  CLIENT_W  client id.
- req_amount  in  AMT_W  order/cancel amount, or new limit.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_accept  out  1  1 = request accepted/applied.
- rsp_reason  out  2  00 ok, 01 limit, 10 bad client, 11 cancel clamped.
- rsp_client  out  CLIENT_W  client id of the response.
- rsp_exposure  out  AMT_W  accumulated exposure after the operation.
- init_done  out  1  table initialisation complete.

Behaviour:
- Clock and reset: one clock (clk); reset (HRESETn) is asynchronous, active-low.
- Reset values: req_ready=0, rsp_valid=0, rsp_accept=0, rsp_reason=00, rsp_client=0, rsp_exposure=0, init_done=0, FSM=INIT, sweep counter=0.
- FSM states: INIT, IDLE, READ, CHECK, WRITE.
- INIT:
  - Writes acc=0, limit=0 to one entry per cycle, index 0..NUM_CLIENTS-1, so it lasts NUM_CLIENTS cycles.
  - Then init_done=1 (sticky until reset) and the FSM goes to IDLE.
  - req_ready=0 throughout.
- IDLE:
  - req_ready=1.
  - Handshake when req_valid && req_ready: op, client and amount are captured, then IDLE->READ.
  - req_ready=0 in every other state, so only one request is outstanding.
- READ: table read of acc and limit for the client; READ->CHECK.
- CHECK: computes the result (next paragraph); CHECK->WRITE.
- WRITE:
  - Commits the table update if any.
  - Drives rsp_valid=1 for exactly this cycle, with rsp_* valid; WRITE->IDLE.
- Latency: handshake at cycle N gives rsp_valid at cycle N+3; the next handshake is possible at N+4.
- Response has no backpressure. rsp_* hold their values until the next response; only rsp_valid pulses.
- Bad client (req_client >= NUM_CLIENTS): no table access or write; rsp_accept=0, rsp_reason=10, rsp_exposure=0.
- Order (00):
  - sum = acc + amount, computed at AMT_W+1 bits, unsigned.
  - Accept iff sum < {1'b0, limit} (strict); then acc <= sum[AMT_W-1:0].
  - Otherwise reject with reason 01 and no write.
  - A strict compare against an AMT_W limit means acc can never overflow.
  - Limit 0 (the reset value) rejects every order, including amount 0.
- Cancel (01):
  - If amount <= acc: acc <= acc - amount, reason 00.
  - Otherwise acc <= 0, reason 11.
  - rsp_accept=1 in both cases.
- Limit update (10):
  - If amount > limit: limit <= amount, accept, reason 00.
  - Otherwise no write, rsp_accept=0, reason 01.
  - rsp_exposure=acc.
- Query (11): no write; rsp_accept=1, reason 00, rsp_exposure=acc.
- Back-to-back requests to the same client are ordered: WRITE completes before the next READ, so there is no forwarding hazard.
- Reset mid-operation: the in-flight request is dropped with no response; the table is re-initialised via INIT.

Optional Feature:
- Macro: LIMIT_DECREASE_EN.
- Defined: limit update always writes limit <= amount, including lowering it or setting 0; rsp_accept=1, reason 00.
  - If the new limit <= acc, later orders reject with reason 01 until cancels bring acc below the limit.
- Undefined: raise-only behaviour as described under Behaviour.

Test Plan:
- Reset, then hold req_valid=1 -> req_ready=0 and init_done=0 for 32 cycles; init_done=1 and req_ready=1 after.
- Order client 3, amount 10, with limit 0 -> rsp_accept=0, reason 01, rsp_exposure=0, rsp_valid exactly 3 cycles after the handshake.
- Limit client 3 := 100, then orders 60 and 39 -> both accepted, exposure 60 then 99; order 1 -> reject reason 01 (100 not < 100), exposure stays 99.
- Client 3 at acc 99: cancel 50 -> exposure 49, reason 00; cancel 80 -> exposure 0, rsp_accept=1, reason 11.
- Limit 0xFFFF on client 31, order 0xFFFE -> accept, exposure 0xFFFE; order 0x0002 -> reject reason 01 (17-bit sum 0x10000); client 32 with NUM_CLIENTS=32 -> reason 10.
- Limit 100 then limit 50 on client 7 -> second update rejected, reason 01 without LIMIT_DECREASE_EN; accepted with it defined, then order 50 rejected. Assert HRESETn in READ -> no rsp_valid, INIT restarts, query returns exposure 0.
